// File: rtl/gate_chk_pkg.sv
// ============================================================================
// Module      : gate_chk_pkg
// Description : Shared constants and FSM state encoding for the gate
//               stimulus checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

  // Vector width, number of exhaustive vectors and error counter width.
  // CNT_W holds NUM_VEC itself, so the error counter can never wrap.
  localparam int VEC_W   = 5;
  localparam int NUM_VEC = 32;
  localparam int CNT_W   = 6;

  // Width of the settle counter; large enough for SETTLE up to 15.
  localparam int SETTLE_W = 4;

  // State encoding
  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_DRIVE  = 2'd1;
  localparam logic [1:0] C_ST_SAMPLE = 2'd2;
  localparam logic [1:0] C_ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = C_ST_IDLE,
    ST_DRIVE  = C_ST_DRIVE,
    ST_SAMPLE = C_ST_SAMPLE,
    ST_DONE   = C_ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
// Module      : gate_ref_model
// Description : Golden combinational model of the gate circuit under test:
//               exp = ((a & b) ^ (c | d)) | e, with vec = {a,b,c,d,e}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [VEC_W-1:0] i_vec,
  output logic             o_exp
);

  logic w_a, w_b, w_c, w_d, w_e;

  // Unpack the vector so the expression reads like the gate schematic
  assign {w_a, w_b, w_c, w_d, w_e} = i_vec;

  assign o_exp = ((w_a & w_b) ^ (w_c | w_d)) | w_e;

endmodule

`default_nettype wire

// File: rtl/gate_stim_checker.sv
// ============================================================================
// Module      : gate_stim_checker
// Description : Exhaustively drives all 32 input vectors onto a 5-input gate
//               circuit, waits SETTLE cycles per vector, compares the
//               response with a golden model and reports error count, first
//               failing vector and pass/fail.
//               Optional macro GATE_CHK_STOP_ON_ERR_EN: when defined, the run
//               ends at the first mismatching vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_stim_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_a,
  output logic             o_b,
  output logic             o_c,
  output logic             o_d,
  output logic             o_e,
  input  logic             i_y,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [VEC_W-1:0] o_err_vec
);

  localparam logic [SETTLE_W-1:0] C_SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0]    C_VEC_LAST    = VEC_W'(NUM_VEC - 1);

  state_t              r_state;
  logic [VEC_W-1:0]    r_vec;
  logic [SETTLE_W-1:0] r_settle;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [VEC_W-1:0]    r_err_vec;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  logic                w_exp;
  logic                w_mismatch;
  logic                w_last;
  logic                w_end_run;
  logic [CNT_W-1:0]    w_err_cnt_next;

  gate_ref_model u_ref (
    .i_vec (r_vec),
    .o_exp (w_exp)
  );

  assign w_mismatch     = (i_y != w_exp);
  assign w_last         = (r_vec == C_VEC_LAST);
  // Error count including the vector being sampled this cycle
  assign w_err_cnt_next = r_err_cnt + CNT_W'(w_mismatch);

`ifdef GATE_CHK_STOP_ON_ERR_EN
  assign w_end_run = w_last | w_mismatch;
`else
  assign w_end_run = w_last;
`endif

  // Run sequencer: drive each vector, settle, sample, and record results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_vec     <= '0;
      r_settle  <= '0;
      r_err_cnt <= '0;
      r_err_vec <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_vec     <= '0;
            r_settle  <= '0;
            r_err_cnt <= '0;
            r_err_vec <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_settle == C_SETTLE_LAST) begin
            r_settle <= '0;
            r_state  <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        ST_SAMPLE: begin
          r_err_cnt <= w_err_cnt_next;
          // Only the first failing vector is kept
          if (w_mismatch && (r_err_cnt == '0)) begin
            r_err_vec <= r_vec;
          end
          if (w_end_run) begin
            // Done and pass are registered so they are valid during DONE
            r_done  <= 1'b1;
            r_pass  <= (w_err_cnt_next == '0);
            r_state <= ST_DONE;
          end else begin
            r_vec   <= r_vec + VEC_W'(1);
            r_state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign {o_a, o_b, o_c, o_d, o_e} = r_vec;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err_cnt;
  assign o_err_vec = r_err_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_stim_checker.sv
// ============================================================================
// Module      : tb_gate_stim_checker
// Description : Scoreboard bench for gate_stim_checker. A fault mask selects
//               which vectors get an inverted response from the simulated
//               gate; the expected run outcome is predicted from the mask and
//               queued when a run is started, and a monitor compares it
//               whenever o_done pulses. Honours GATE_CHK_STOP_ON_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_stim_checker;

  localparam int SETTLE  = 3;
  localparam int VEC_CYC = SETTLE + 1;

  typedef struct {
    int cnt;
    int evec;
    int pass;
    int dur;
    int lastv;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a, b, c, d, e;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_cnt;
  logic [4:0] err_vec;

  bit [31:0]  mask;
  exp_t       sb[$];
  int         checks;
  int         errors;
  int         cyc;

  gate_stim_checker #(.SETTLE(SETTLE)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .o_a       (a),
    .o_b       (b),
    .o_c       (c),
    .o_d       (d),
    .o_e       (e),
    .i_y       (y),
    .o_busy    (busy),
    .o_done    (done),
    .o_pass    (pass),
    .o_err_cnt (err_cnt),
    .o_err_vec (err_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Truth of the gate from its boolean description, using integer arithmetic
  function automatic bit gate_true(int v);
    int ia, ib, ic, id, ie, cd_or;
    ia = (v >> 4) & 1;
    ib = (v >> 3) & 1;
    ic = (v >> 2) & 1;
    id = (v >> 1) & 1;
    ie = v & 1;
    cd_or = ((ic + id) > 0) ? 1 : 0;
    return ((ia * ib) != cd_or) || (ie == 1);
  endfunction

  // Simulated circuit under test: correct gate, inverted where mask is set
  assign y = gate_true(int'({a, b, c, d, e})) ^ mask[{a, b, c, d, e}];

  function automatic exp_t predict(bit [31:0] m);
    exp_t r;
    r.cnt   = 0;
    r.evec  = 0;
    r.dur   = 32 * VEC_CYC;
    r.lastv = 31;
    for (int v = 0; v < 32; v++) begin
      if (m[v]) begin
        if (r.cnt == 0) r.evec = v;
        r.cnt++;
`ifdef GATE_CHK_STOP_ON_ERR_EN
        r.dur   = (v + 1) * VEC_CYC;
        r.lastv = v;
        break;
`endif
      end
    end
    r.pass = (r.cnt == 0) ? 1 : 0;
    return r;
  endfunction

  function automatic bit [31:0] mask_stuck(bit level);
    bit [31:0] m;
    for (int v = 0; v < 32; v++) m[v] = (gate_true(v) != level);
    return m;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops one expectation per o_done pulse
  initial begin : monitor
    bit   prev_busy;
    bit   prev_done;
    int   t_start;
    exp_t x;
    prev_busy = 0;
    prev_done = 0;
    t_start   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 0;
        prev_done = 0;
      end else begin
        if (busy && !prev_busy) t_start = cyc;
        if (done) begin
          chk("done_single_cycle", int'(prev_done), 0);
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            x = sb.pop_front();
            chk("err_cnt", int'(err_cnt), x.cnt);
            chk("err_vec", int'(err_vec), x.evec);
            chk("pass", int'(pass), x.pass);
            chk("run_cycles", cyc - t_start, x.dur);
            chk("busy_in_done", int'(busy), 1);
          end
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  task automatic wait_idle();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == 2000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_vec(int v);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (int'({a, b, c, d, e}) == v) break;
    end
    if (n == 2000) chk("vec_timeout", 1, 0);
  endtask

  task automatic check_held(exp_t x);
    repeat (2) @(negedge clk);
    chk("held_busy", int'(busy), 0);
    chk("held_done", int'(done), 0);
    chk("held_err_cnt", int'(err_cnt), x.cnt);
    chk("held_err_vec", int'(err_vec), x.evec);
    chk("held_pass", int'(pass), x.pass);
    chk("held_vec", int'({a, b, c, d, e}), x.lastv);
  endtask

  // One complete run; optional ignored start pulse at vector 10
  task automatic run(bit [31:0] m, bit spurious);
    exp_t x;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    mask = m;
    x = predict(m);
    start = 1'b1;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    if (spurious) begin
      wait_vec(10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    check_held(x);
  endtask

  initial begin : stim
    exp_t x;
    bit [31:0] m;
    checks = 0;
    errors = 0;
    cyc    = 0;
    mask   = '0;
    start  = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_err_vec", int'(err_vec), 0);
    chk("rst_vec", int'({a, b, c, d, e}), 0);
    rst_n = 1'b1;

    // Correct gate, with an ignored start mid-run
    run('0, 1'b1);
    // Response stuck at 1, then stuck at 0
    run(mask_stuck(1'b1), 1'b0);
    run(mask_stuck(1'b0), 1'b0);
    // Single fault at vector 5'b11000
    run(32'h1 << 24, 1'b0);

    // Start held high: two back-to-back runs
    @(negedge clk);
    mask = 32'h0000_0100 | 32'h8000_0000;
    x = predict(mask);
    start = 1'b1;
    sb.push_back(x);
    sb.push_back(x);
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    chk("b2b_restart", int'(busy), 1);
    start = 1'b0;
    wait_idle();
    check_held(x);

    // Reset in the middle of a run aborts it
    mask = '0;
    start = 1'b1;
    sb.push_back(predict(mask));
    @(negedge clk);
    start = 1'b0;
    wait_vec(17);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err_cnt", int'(err_cnt), 0);
    chk("abort_vec", int'({a, b, c, d, e}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);
    run('0, 1'b0);

    // Randomised fault masks
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       m = $urandom();
        1:       m = $urandom() & $urandom() & $urandom();
        2:       m = 32'h1 << $urandom_range(0, 31);
        default: m = '0;
      endcase
      run(m, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_stim_checker.md
GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

Interface
- REQ-001: Parameter SETTLE, default 1, range 1..15: cycles each vector is driven before the response is sampled.
- REQ-002: i_clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: i_rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-004: i_start  input  1  run request, sampled on the rising edge; acted on only in IDLE.
- REQ-005: o_a, o_b, o_c, o_d, o_e  output  1 each  stimulus to the gate circuit under test; registered.
- REQ-006: i_y  input  1  response from the gate circuit under test.
- REQ-007: o_busy  output  1  high in every state except IDLE.
- REQ-008: o_done  output  1  one-cycle pulse at end of run.
- REQ-009: o_pass  output  1  result of the last completed run.
- REQ-010: o_err_cnt  output  6  number of mismatching vectors in the last or current run.
- REQ-011: o_err_vec  output  5  first mismatching vector {a,b,c,d,e}; valid when o_err_cnt is nonzero.

Function
- REQ-012: The block SHALL drive a 5-bit vector counter vec as {o_a,o_b,o_c,o_d,o_e}, with vec[4]=a and vec[0]=e, stepping 0..31 in ascending order.
- REQ-013: The expected response SHALL be exp = ((a AND b) XOR (c OR d)) OR e, computed on the driven vector.
- REQ-014: The FSM SHALL have these states: IDLE, DRIVE, SAMPLE, DONE.
- REQ-015: In IDLE, when i_start=1, the block SHALL clear vec, the settle counter, o_err_cnt and o_err_vec, and then enter DRIVE.
- REQ-016: The block SHALL stay in DRIVE for exactly SETTLE cycles and then enter SAMPLE, holding vec stable throughout.
- REQ-017: In SAMPLE, the block SHALL compare i_y with exp for one cycle.
  - On mismatch, o_err_cnt increments.
  - If o_err_cnt was 0 before the increment, vec is captured into o_err_vec.
- REQ-018: From SAMPLE, the block SHALL go to DONE if vec=31; otherwise it increments vec and returns to DRIVE.
- REQ-019: Each vector SHALL occupy SETTLE+1 cycles, and a full run SHALL take 32*(SETTLE+1) cycles from DRIVE entry to DONE entry.
- REQ-020: DONE SHALL last one cycle, with o_done=1 and o_pass=(final o_err_cnt==0), and then return to IDLE.
- REQ-021: o_pass, o_err_cnt and o_err_vec SHALL hold their values until the next accepted i_start.
- REQ-022: i_start while o_busy=1 SHALL be ignored, and i_start held high SHALL produce back-to-back runs, one per IDLE visit.
- REQ-023: o_err_cnt SHALL NOT wrap, because its maximum value of 32 fits in 6 bits.

Reset
- REQ-024: While i_rst_n=0, all registers SHALL reset asynchronously.
  - State=IDLE, vec=0, so o_a..o_e=0.
  - o_busy=0, o_done=0, o_pass=0, o_err_cnt=0, o_err_vec=0.
- REQ-025: Reset during a run SHALL abort it without an o_done pulse, and the block SHALL wait in IDLE for a new i_start after release.

Configuration
- REQ-026: Macro GATE_CHK_STOP_ON_ERR_EN selects stop-on-error behaviour.
  - Defined: the first mismatch in SAMPLE goes directly to DONE, leaving o_err_cnt=1, o_pass=0, and o_err_vec and vec at the failing vector.
  - Undefined: all 32 vectors always run.

Structure
- REQ-027: Package gate_chk_pkg SHALL hold the state encoding constants, VEC_W=5, NUM_VEC=32 and CNT_W=6.
- REQ-028: Sub-module gate_ref_model SHALL implement the combinational exp function from REQ-013, taking 5 bits in and producing 1 bit out, and SHALL be instantiated once.

Verification
- REQ-029: i_y driven by a correct gate model, SETTLE=1, i_start pulse -> o_done at 64 cycles after DRIVE entry, o_pass=1, o_err_cnt=0.
- REQ-030: i_y tied to 1 -> o_err_cnt=6, o_err_vec=5'b00000, o_pass=0.
- REQ-031: i_y tied to 0 -> o_err_cnt=26, o_err_vec=5'b00001, o_pass=0.
  - With GATE_CHK_STOP_ON_ERR_EN defined: o_err_cnt=1, o_err_vec=5'b00001, o_done 2*(SETTLE+1) cycles after DRIVE entry.
- REQ-032: SETTLE=3 with a correct model, and a second i_start pulse at vector 10 -> run length 128 cycles, second start ignored, exactly one o_done pulse.
- REQ-033: i_rst_n pulsed low at vector 17 -> all outputs take reset values immediately, no o_done pulse, and a new i_start gives a clean full run.
- REQ-034: Correct model with i_y forced inverted only at vector 5'b11000 -> o_err_cnt=1, o_err_vec=5'b11000.
